// File: rtl/cdc_hs_src.sv
// Source side of a 4-phase req/ack handshake carrying one DW-bit word into a
// slower clock domain; ack_i is synchronized locally, words offered while busy are counted.
module cdc_hs_src #(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          req_o,
  output logic [DW-1:0] data_o,
  input  logic          ack_i,
  output logic          done_o,
  output logic [CW-1:0] drop_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   req_q, req_d;
  logic [DW-1:0]          data_q, data_d;
  logic                   done_q, done_d;
  logic [CW-1:0]          drop_q, drop_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_i};
    end
  end

  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // Handshake: a word is taken on any edge where valid_i and ready_o are both 1;
  // valid_i while ready_o is 0 is discarded and counted as a drop.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          data_d  = data_i;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ACK_LOW;
        end
      end
      ACK_LOW: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (valid_i && (state_q != IDLE) && (drop_q != {CW{1'b1}})) begin
      drop_d = drop_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  // done_q rises on the same edge that returns the FSM to IDLE, so it lines up with ready_o.
  assign ready_o    = (state_q == IDLE);
  assign req_o      = req_q;
  assign data_o     = data_q;
  assign done_o     = done_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_cdc_hs_src.sv
// Bench for cdc_hs_src: directed handshake/latency/drop/reset checks plus a
// random stream through a 2:1 slow-clock destination model feeding a scoreboard.
module tb_cdc_hs_src;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int CW = 8;

  // clock / reset
  logic clk = 1'b0;
  logic slow_clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;
  initial begin
    #2;
    forever #10 slow_clk = ~slow_clk;
  end

  logic          valid_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          ready_o, req_o, done_o;
  logic [DW-1:0] data_o;
  logic [CW-1:0] drop_cnt_o;
  logic          ack_i;
  logic          ack_man = 1'b0;
  logic          ack_model = 1'b0;
  logic          auto_ack = 1'b0;

  assign ack_i = auto_ack ? ack_model : ack_man;

  cdc_hs_src #(.DW(DW), .SYNC_STAGES(SS), .CW(CW)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .req_o      (req_o),
    .data_o     (data_o),
    .ack_i      (ack_i),
    .done_o     (done_o),
    .drop_cnt_o (drop_cnt_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int rx_cnt = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    valid_i = 1'b1;
    data_i  = w;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (!ready_o && n < max_cyc) begin
      tick();
      n++;
    end
    check("idle_wait", ready_o, 1);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick();
      n++;
    end
    check("sb_drain", exp_q.size(), 0);
  endtask

  // Manual ack cycle with exact latency checks; assumes the FSM is in REQ.
  task automatic complete_manual(input string tag);
    ack_man = 1'b1;
    repeat (SS) begin
      tick();
      check({tag, "_req_hold"}, req_o, 1);
    end
    tick();
    check({tag, "_req_fall"}, req_o, 0);
    ack_man = 1'b0;
    repeat (SS) begin
      tick();
      check({tag, "_done_early"}, done_o, 0);
    end
    tick();
    check({tag, "_done"}, done_o, 1);
    check({tag, "_done_ready"}, ready_o, 1);
  endtask

  // scoreboard: slow-domain destination model pops the expected queue on capture
  initial begin
    forever begin
      @(posedge slow_clk);
      if (auto_ack) begin
        if (!ack_model && req_o) begin
          if (exp_q.size() == 0) begin
            check("sb_empty", exp_q.size(), 1);
          end else begin
            check("rx_data", data_o, exp_q.pop_front());
            rx_cnt++;
          end
          ack_model = 1'b1;
        end else if (ack_model && !req_o) begin
          ack_model = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done_o) done_cnt++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_base;
    int sent;
    int n;
    logic [DW-1:0] w;

    // reset values held with valid_i toggling
    for (int i = 0; i < 5; i++) begin
      valid_i = i[0];
      data_i  = 8'hFF;
      tick();
      check("rst_req", req_o, 0);
      check("rst_ready", ready_o, 1);
      check("rst_done", done_o, 0);
      check("rst_drop", drop_cnt_o, 0);
    end
    valid_i = 1'b0;
    rst_i   = 1'b0;
    tick();

    // single transfer with three drops while in REQ
    send_word(8'hA5);
    check("t1_req", req_o, 1);
    check("t1_data", data_o, 8'hA5);
    check("t1_ready", ready_o, 0);
    send_word(8'h11);
    tick();
    send_word(8'h22);
    send_word(8'h33);
    check("drop3_cnt", drop_cnt_o, 3);
    check("drop3_data", data_o, 8'hA5);
    complete_manual("t1");

    // back-to-back: valid in the done cycle is accepted
    send_word(8'h5A);
    check("b2b_req", req_o, 1);
    check("b2b_data", data_o, 8'h5A);
    check("b2b_done_clr", done_o, 0);
    complete_manual("b2b");
    tick();
    check("b2b_done_pulse", done_o, 0);

    // random stream through the slow-domain ack model
    auto_ack  = 1'b1;
    done_base = done_cnt;
    rx_cnt    = 0;
    sent      = 0;
    n         = 0;
    while (sent < 100 && n < 20000) begin
      if (ready_o && ($urandom_range(0, 1) == 1)) begin
        w       = DW'($urandom_range(0, 255));
        valid_i = 1'b1;
        data_i  = w;
        exp_q.push_back(w);
        sent++;
      end else begin
        valid_i = 1'b0;
      end
      tick();
      n++;
    end
    valid_i = 1'b0;
    check("rand_sent", sent, 100);
    wait_drain(5000);
    wait_idle(200);
    tick();
    check("rand_rx_cnt", rx_cnt, 100);
    check("rand_done_cnt", done_cnt - done_base, 100);
    check("rand_drop", drop_cnt_o, 3);
    auto_ack = 1'b0;

    // saturation: 300 drops while stuck in REQ
    send_word(8'h77);
    valid_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      data_i = DW'(i);
      tick();
    end
    valid_i = 1'b0;
    check("sat_cnt", drop_cnt_o, 255);
    check("sat_data", data_o, 8'h77);
    complete_manual("sat");

    // asynchronous reset in the middle of a transfer
    send_word(8'h99);
    tick();
    check("mid_req_pre", req_o, 1);
    rst_i = 1'b1;
    #1;
    check("mid_req", req_o, 0);
    check("mid_ready", ready_o, 1);
    check("mid_drop", drop_cnt_o, 0);
    check("mid_data", data_o, 0);
    #1;
    rst_i = 1'b0;

    // a new word transfers normally after reset
    auto_ack  = 1'b1;
    done_base = done_cnt;
    exp_q.push_back(8'h3C);
    send_word(8'h3C);
    check("post_req", req_o, 1);
    check("post_data", data_o, 8'h3C);
    wait_drain(500);
    wait_idle(200);
    tick();
    check("post_done_cnt", done_cnt - done_base, 1);
    check("post_drop", drop_cnt_o, 0);
    auto_ack = 1'b0;

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
